gpio_led_ctrl: RTL
==================

Name: gpio_led_ctrl

Overview:
Register-and-sequence controller for the 0xF0000000 GPIO/LED peripheral port. It captures CPU store data on the write strobe into a holding register and splits it into counter_set, the LED field and the upper GPIO field. A small FSM blinks the LEDs autonomously at a programmable rate and raises a one-cycle write acknowledge for the bus side.

Parameters:
PRESCALE, 32'd25_000_000, base number of clk cycles per blink half-period (rate 0); must be >= 1
CNT_W, 32, width of the internal tick counter; must hold (PRESCALE << 3) - 1

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
GPIOf0000000_we  input  1  write strobe for address 0xF0000000, sampled each rising edge
Peripheral_in  input  32  CPU store data
counter_set  output  2  counter channel select, registered from Peripheral_in[1:0]
led_out  output  8  LED drive; equals the LED field or 0 during the blink OFF phase
GPIOf0  output  22  registered Peripheral_in[31:10]
wr_ack  output  1  one-cycle pulse the cycle after each accepted write
blink_phase  output  1  1 while the FSM is in OFF, otherwise 0

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. On reset: ctrl_q = 0, so counter_set = 0, led_out = 0, GPIOf0 = 0. Also wr_ack = 0, blink_phase = 0, tick counter = 0, state = IDLE.
- Field map of ctrl_q: [1:0] counter_set, [9:2] led field, [31:10] GPIOf0. Decoded control bits:
  - GPIOf0[0] = blink_en
  - GPIOf0[2:1] = rate
- Write: if we = 1 at an edge, ctrl_q <= Peripheral_in. All outputs reflect the new value after that edge (latency 1). wr_ack = 1 for the following cycle only.
- If we is held high for N cycles, that is N writes and N ack cycles. The last value wins.
- Half-period: HP = PRESCALE << rate cycles (rate 0..3 gives x1, x2, x4, x8).
- FSM states:
  - IDLE: led_out = led field. If blink_en, go to ON with tick = 0.
  - ON: led_out = led field. Tick increments. At tick == HP-1: tick <= 0, go to OFF.
  - OFF: led_out = 0, blink_phase = 1. At tick == HP-1: tick <= 0, go to ON.
- Any write while in ON or OFF:
  - If the new blink_en = 1, restart in ON with tick = 0.
  - If the new blink_en = 0, go to IDLE with tick = 0.
  - Write has priority over a same-cycle tick expiry.
- Tick counter never exceeds HP-1. There is no wrap-around beyond that, and rate changes take effect only through a write, which restarts the count.
- rst asserted mid-blink or together with we: reset wins. The write is discarded and no wr_ack is raised.
- counter_set and GPIOf0 are never gated by the blink phase.

Optional Feature:
Macro GPIO_READBACK_EN.
- Defined: adds output port gpio_rdata[31:0].
  - Combinational view of {GPIOf0, led_out, counter_set}, i.e. live LED state including the blink phase.
  - Lets the CPU read the port back.
- Not defined: the port is absent and no readback logic exists.
- Write behaviour is identical in both cases.

Decomposition:
- Shared package gpio_pkg holds:
  - field bit positions (CS_LSB = 0, LED_LSB = 2, GPIO_LSB = 10)
  - blink_en bit index and rate field index
  - FSM state encoding typedef {IDLE, ON, OFF}, 2 bits
  - the 0xF0000000 base address constant
- One natural sub-module: blink_timer, holding the tick counter plus the HP = PRESCALE << rate compare. It has inputs clear and rate, and output expire.
- Register capture and FSM stay in the top.

Test Plan:
- Reset release, no writes -> all outputs 0, wr_ack 0, state IDLE for 100 cycles.
- Single write 0x0000_03FD with blink_en = 0 -> next cycle: counter_set = 2'b01, led_out = 8'hFF, GPIOf0 = 0; wr_ack high exactly 1 cycle.
- PRESCALE = 4. Write 0x0000_07FC, i.e. led 8'hFF, blink_en = 1, rate 0 -> led_out = 8'hFF for 4 cycles, then 0 for 4 cycles, repeating; blink_phase matches.
- PRESCALE = 4. Write with rate = 3 and blink_en = 1 -> half-period 32 cycles. A mid-OFF write of 0x0000_0028 (blink_en = 0, led 8'h0A) -> led_out = 8'h0A next cycle, state IDLE.
- we held 3 cycles with data 1, 2, 3 -> 3 wr_ack cycles; final ctrl_q = 3, so counter_set = 2'b11.
- rst and we asserted on the same edge during blink -> outputs 0, no wr_ack, IDLE. With GPIO_READBACK_EN defined, gpio_rdata = 0.

Source files
------------

// File: rtl/gpio_led_ctrl_pkg.sv
// Shared definitions for the 0xF0000000 GPIO/LED port: field positions,
// decoded control bit indices and the blink FSM state encoding.
package gpio_pkg;

  localparam logic [31:0] GPIO_BASE_ADDR = 32'hF000_0000;

  localparam int CS_LSB   = 0;
  localparam int CS_W     = 2;
  localparam int LED_LSB  = 2;
  localparam int LED_W    = 8;
  localparam int GPIO_LSB = 10;
  localparam int GPIO_W   = 22;

  // Indices within the GPIOf0 field
  localparam int BLINK_EN_BIT = 0;
  localparam int RATE_LSB     = 1;
  localparam int RATE_W       = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } blink_state_t;

endpackage

// File: rtl/gpio_led_ctrl_blink_timer.sv
// Half-period tick counter for the LED blinker; HP = PRESCALE << rate.
module blink_timer
  import gpio_pkg::*;
#(
  parameter int unsigned PRESCALE = 32'd25_000_000,
  parameter int          CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              run,
  input  logic [RATE_W-1:0] rate,
  output logic              expire
);

  logic [CNT_W-1:0] tick;
  logic [CNT_W-1:0] hp_m1;

  assign hp_m1  = (CNT_W'(PRESCALE) << rate) - CNT_W'(1);
  assign expire = run && (tick == hp_m1);

  // Clear wins over counting so a write always restarts from zero
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      tick <= '0;
    end else if (run) begin
      tick <= expire ? '0 : tick + CNT_W'(1);
    end
  end

endmodule

// File: rtl/gpio_led_ctrl.sv
// GPIO/LED register port with autonomous blinker and one-cycle write ack.
// Optional macro GPIO_READBACK_EN adds the gpio_rdata readback output.
module gpio_led_ctrl
  import gpio_pkg::*;
#(
  parameter int unsigned PRESCALE = 32'd25_000_000,
  parameter int          CNT_W    = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        GPIOf0000000_we,
  input  logic [31:0] Peripheral_in,
  output logic [1:0]  counter_set,
  output logic [7:0]  led_out,
  output logic [21:0] GPIOf0,
  output logic        wr_ack,
`ifdef GPIO_READBACK_EN
  output logic [31:0] gpio_rdata,
`endif
  output logic        blink_phase
);

  logic [31:0]       ctrl_q;
  blink_state_t      state_q;
  blink_state_t      state_d;
  logic              blink_en;
  logic              new_blink_en;
  logic [RATE_W-1:0] rate;
  logic              timer_clear;
  logic              timer_run;
  logic              expire;

  assign counter_set  = ctrl_q[CS_LSB +: CS_W];
  assign GPIOf0       = ctrl_q[GPIO_LSB +: GPIO_W];
  assign blink_en     = GPIOf0[BLINK_EN_BIT];
  assign rate         = GPIOf0[RATE_LSB +: RATE_W];
  assign new_blink_en = Peripheral_in[GPIO_LSB + BLINK_EN_BIT];

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q  <= '0;
      wr_ack  <= 1'b0;
      state_q <= IDLE;
    end else begin
      if (GPIOf0000000_we) ctrl_q <= Peripheral_in;
      wr_ack  <= GPIOf0000000_we;
      state_q <= state_d;
    end
  end

  // A write restarts the blinker from ON (or parks it) and beats tick expiry
  always_comb begin
    state_d     = state_q;
    timer_clear = GPIOf0000000_we || (state_q == IDLE);
    timer_run   = (state_q == ON) || (state_q == OFF);
    case (state_q)
      IDLE:    if (blink_en) state_d = ON;
      ON:      if (expire) state_d = OFF;
      OFF:     if (expire) state_d = ON;
      default: state_d = IDLE;
    endcase
    if (GPIOf0000000_we) state_d = new_blink_en ? ON : IDLE;
  end

  blink_timer #(
    .PRESCALE (PRESCALE),
    .CNT_W    (CNT_W)
  ) u_blink_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .run    (timer_run),
    .rate   (rate),
    .expire (expire)
  );

  assign blink_phase = (state_q == OFF);
  assign led_out     = blink_phase ? 8'h00 : ctrl_q[LED_LSB +: LED_W];

`ifdef GPIO_READBACK_EN
  assign gpio_rdata = {GPIOf0, led_out, counter_set};
`endif

endmodule
